// File: rtl/gcd_pkg.sv
// Shared types and widths for the GCD operand sequencer and its timer.
package gcd_pkg;
   localparam int unsigned GCD_WIDTH = 16;
   localparam int unsigned CYC_W     = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_WAIT,
      S_OUT
   } seq_state_t;
endpackage

// File: rtl/gcd_wait_timer.sv
// WAIT-phase cycle counter with clear, enable and terminal-count detect.
module gcd_wait_timer
   import gcd_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   output logic [CYC_W-1:0] count,
   output logic             expired
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + CYC_W'(1);
      end
   end

   // Asserted in the enabled cycle that brings the count up to TIMEOUT.
   assign expired = en && (count == CYC_W'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Serialises operand pairs onto the GCD core bus and returns its result,
// with zero-operand bypass, stale-done rejection and a wait timeout.
module gcd_operand_sequencer
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH   = GCD_WIDTH,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic [CYC_W-1:0] out_cycles,
   output logic             out_err,
   output logic             core_start,
   output logic [WIDTH-1:0] core_data,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_gcd
);

   seq_state_t       state, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
   logic [CYC_W-1:0] cyc_q, cyc_d, count;
   logic             err_q, err_d, armed_q, armed_d;
   logic             tmr_clr, tmr_en, expired;

   gcd_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clr),
      .en      (tmr_en),
      .count   (count),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         cyc_q   <= '0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state   <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      cyc_d   = cyc_q;
      err_d   = err_q;
      armed_d = armed_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               a_d = in_a;
               b_d = in_b;
               // The core never terminates on a zero operand; answer directly.
               if (in_a == '0 || in_b == '0) begin
                  gcd_d   = in_a | in_b;
                  cyc_d   = '0;
                  err_d   = 1'b0;
                  state_d = S_OUT;
               end else begin
                  state_d = S_LOAD_A;
               end
            end
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: begin
            armed_d = 1'b0;
            tmr_clr = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tmr_en = 1'b1;
            if (!core_done) begin
               armed_d = 1'b1;
            end
            // A done level is only trusted after it has been seen low.
            if (core_done && armed_q) begin
               gcd_d   = core_gcd;
               cyc_d   = count + CYC_W'(1);
               err_d   = 1'b0;
               state_d = S_OUT;
            end else if (expired) begin
               gcd_d   = '0;
               cyc_d   = CYC_W'(TIMEOUT);
               err_d   = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_data = '0;
      case (state)
         S_LOAD_A:         core_data = a_q;
         S_LOAD_B, S_WAIT: core_data = b_q;
         default:          core_data = '0;
      endcase
   end

   assign in_ready   = (state == S_IDLE);
   assign out_valid  = (state == S_OUT);
   assign core_start = (state == S_LOAD_A);
   assign out_gcd    = gcd_q;
   assign out_cycles = cyc_q;
   assign out_err    = err_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Randomised and directed bench for gcd_operand_sequencer with a behavioural core.
module tb_gcd_operand_sequencer;
   localparam int unsigned W  = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          core_done = 1'b0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [W-1:0]  core_gcd = '0;
   logic          in_ready, out_valid, out_err, core_start;
   logic [W-1:0]  out_gcd, core_data;
   logic [15:0]   out_cycles;

   int checks = 0;
   int failures = 0;

   // Observations from the most recent operation
   int            r_starts, r_vlat;
   logic [W-1:0]  r_d1, r_d2, r_dw, r_dout, r_gcd;
   logic [15:0]   r_cyc;
   logic          r_err;

   always #5 clk = ~clk;

   gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_gcd    (out_gcd),
      .out_cycles (out_cycles),
      .out_err    (out_err),
      .core_start (core_start),
      .core_data  (core_data),
      .core_done  (core_done),
      .core_gcd   (core_gcd)
   );

   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Issue one pair and play the core: done (if stale) high through the load
   // phase, low in WAIT until cycle lat, then high with res. lat=0: never done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit stale, input logic [W-1:0] res);
      int t;
      int w;
      r_starts = 0; r_vlat = 0; r_d1 = 'x; r_d2 = 'x; r_dw = 'x; r_dout = 'x;
      r_gcd = 'x; r_cyc = 'x; r_err = 1'bx;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b;
      core_done = stale; core_gcd = stale ? 16'hdead : '0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 50);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         w = k - 2;
         if (k > 2) begin
            core_done = (lat != 0 && w >= lat);
            core_gcd  = core_done ? res : (stale ? 16'hdead : '0);
         end else if (!stale) begin
            core_done = 1'b0;
         end
         @(negedge clk);
         if (core_start === 1'b1) r_starts++;
         if (k == 1) r_d1 = core_data;
         if (k == 2) r_d2 = core_data;
         if (k == 3) r_dw = core_data;
         if (out_valid === 1'b1) begin
            r_vlat = k; r_gcd = out_gcd; r_cyc = out_cycles; r_err = out_err; r_dout = core_data;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({in_ready, out_valid, out_err, core_start} !== 4'b1000 || out_gcd !== '0 ||
          out_cycles !== '0 || core_data !== '0) begin
         failures++;
         $display("FAIL reset: rdy/vld/err/start=%b%b%b%b gcd=%0d cyc=%0d data=%0d required 1000 0 0 0",
                  in_ready, out_valid, out_err, core_start, out_gcd, out_cycles, core_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_op(16'd36, 16'd24, 5, 1'b0, 16'd12);
      checks++;
      if (r_starts !== 1) begin failures++; $display("FAIL basic_start_count: got %0d required 1", r_starts); end
      checks++;
      if (r_d1 !== 16'd36 || r_d2 !== 16'd24 || r_dw !== 16'd24) begin
         failures++; $display("FAIL basic_core_data: got %0d,%0d,%0d required 36,24,24", r_d1, r_d2, r_dw);
      end
      checks++;
      if (r_vlat !== 8) begin failures++; $display("FAIL basic_latency: got E+%0d required E+8", r_vlat); end
      checks++;
      if (r_gcd !== 16'd12 || r_cyc !== 16'd5 || r_err !== 1'b0) begin
         failures++; $display("FAIL basic_result: gcd=%0d cyc=%0d err=%b required 12 5 0", r_gcd, r_cyc, r_err);
      end
      checks++;
      if (r_dout !== '0) begin failures++; $display("FAIL basic_data_in_out: got %0d required 0", r_dout); end
      finish_out();
   endtask

   task automatic test_bypass();
      logic [W-1:0] av [3];
      logic [W-1:0] bv [3];
      av[0] = 16'd0; bv[0] = 16'd7;
      av[1] = 16'd0; bv[1] = 16'd0;
      av[2] = 16'd9; bv[2] = 16'd0;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], 0, 1'b0, '0);
         checks++;
         if (r_vlat !== 1 || r_starts !== 0 || r_gcd !== (av[i] | bv[i]) || r_cyc !== '0 || r_err !== 1'b0) begin
            failures++;
            $display("FAIL bypass_%0d: lat=%0d starts=%0d gcd=%0d cyc=%0d err=%b required 1 0 %0d 0 0",
                     i, r_vlat, r_starts, r_gcd, r_cyc, r_err, av[i] | bv[i]);
         end
         finish_out();
      end
   endtask

   task automatic test_timeout();
      run_op(16'd100, 16'd75, 0, 1'b0, '0);
      checks++;
      if (r_vlat !== 11 || r_gcd !== '0 || r_cyc !== 16'(TO) || r_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout: lat=%0d gcd=%0d cyc=%0d err=%b required 11 0 %0d 1", r_vlat, r_gcd, r_cyc, r_err, TO);
      end
      finish_out();
      // done in the very cycle the count reaches TIMEOUT: acceptance wins
      run_op(16'd100, 16'd75, int'(TO), 1'b0, 16'd25);
      checks++;
      if (r_vlat !== 11 || r_gcd !== 16'd25 || r_cyc !== 16'(TO) || r_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_tie: lat=%0d gcd=%0d cyc=%0d err=%b required 11 25 %0d 0", r_vlat, r_gcd, r_cyc, r_err, TO);
      end
      finish_out();
   endtask

   task automatic test_stale_done();
      run_op(16'd15, 16'd10, 3, 1'b1, 16'd5);
      checks++;
      if (r_vlat !== 6 || r_gcd !== 16'd5 || r_cyc !== 16'd3 || r_err !== 1'b0 || r_starts !== 1) begin
         failures++;
         $display("FAIL stale_done: lat=%0d gcd=%0d cyc=%0d err=%b starts=%0d required 6 5 3 0 1",
                  r_vlat, r_gcd, r_cyc, r_err, r_starts);
      end
      finish_out();
      core_done = 1'b0;
   endtask

   task automatic test_backpressure();
      bit stable;
      run_op(16'd12, 16'd18, 2, 1'b0, 16'd6);
      in_valid = 1'b1; in_a = 16'd0; in_b = 16'd9;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(out_valid === 1'b1 && out_gcd === 16'd6 && out_cycles === 16'd2 &&
               out_err === 1'b0 && in_ready === 1'b0)) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL backpressure_hold: vld=%b gcd=%0d cyc=%0d rdy=%b required 1 6 2 0",
                  out_valid, out_gcd, out_cycles, in_ready);
      end
      finish_out();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_gcd !== 16'd9 || out_cycles !== '0) begin
         failures++;
         $display("FAIL backpressure_second: vld=%b gcd=%0d cyc=%0d required 1 9 0", out_valid, out_gcd, out_cycles);
      end
      finish_out();
   endtask

   task automatic test_reset_mid();
      int t;
      bit seen;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 16'd50; in_b = 16'd20; core_done = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 50);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_err, core_start} !== 4'b1000 || out_gcd !== '0 ||
          out_cycles !== '0 || core_data !== '0) begin
         failures++;
         $display("FAIL reset_mid_async: rdy/vld/err/start=%b%b%b%b gcd=%0d cyc=%0d data=%0d required 1000 0 0 0",
                  in_ready, out_valid, out_err, core_start, out_gcd, out_cycles, core_data);
      end
      core_done = 1'b1; core_gcd = 16'd10;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready: got %b required 1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || core_start !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL reset_mid_no_result: activity seen=1 required 0"); end
      core_done = 1'b0;
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, g;
      int lat;
      bit byp;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom_range(1, 2000));
         b = W'($urandom_range(1, 2000));
         if ($urandom_range(0, 3) == 0) a = '0;
         lat = int'($urandom_range(2, TO - 1));
         g = ref_gcd(a, b);
         byp = (a == 0 || b == 0);
         run_op(a, b, lat, 1'b0, g);
         checks++;
         if (r_vlat !== (byp ? 1 : lat + 3) || r_gcd !== g || r_cyc !== (byp ? 16'd0 : 16'(lat)) ||
             r_err !== 1'b0 || r_starts !== (byp ? 0 : 1)) begin
            failures++;
            $display("FAIL random_%0d a=%0d b=%0d: lat=%0d gcd=%0d cyc=%0d err=%b starts=%0d required %0d %0d %0d 0 %0d",
                     i, a, b, r_vlat, r_gcd, r_cyc, r_err, r_starts,
                     byp ? 1 : lat + 3, g, byp ? 0 : lat, byp ? 0 : 1);
         end
         finish_out();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_timeout();
      test_stale_done();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
